// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode encodings, NZCV flag bit positions and the
// self-test vector record used by the BIST ROM and controller.
package alu_defs;

  localparam int ALU_N = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  // Flag vectors are always ordered {N, Z, C, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    alu_op_e          op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [ALU_N-1:0] result;
    logic [3:0]       flags;
    logic [3:0]       mask;
  } vec_t;

endpackage

// File: rtl/alu_bist_rom.sv
// Directed ALU self-test vectors, combinational lookup by vector index.
// Zero latency; no flow control.
module alu_bist_rom
  import alu_defs::*;
(
  input  logic [2:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec = '0;
    case (idx)
      3'd0: vec = '{op: OP_OR,  a: 32'h80D0_0000, b: 32'h80D0_00F0,
                    result: 32'h80D0_00F0, flags: 4'b1000, mask: 4'b1111};
      3'd1: vec = '{op: OP_AND, a: 32'h80D0_0040, b: 32'h80D0_00F0,
                    result: 32'h80D0_0040, flags: 4'b1000, mask: 4'b1111};
      3'd2: vec = '{op: OP_ADD, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF,
                    result: 32'hFFFF_FFFE, flags: 4'b1001, mask: 4'b1111};
      3'd3: vec = '{op: OP_SUB, a: 32'h0000_0000, b: 32'hFFFF_FFFF,
                    result: 32'h0000_0001, flags: 4'b0000, mask: 4'b1111};
      // SLT flags are implementation-defined, so only the result is checked.
      3'd4: vec = '{op: OP_SLT, a: 32'h80D0_0000, b: 32'h80D0_00F0,
                    result: 32'h0000_0001, flags: 4'b0000, mask: 4'b0000};
      3'd5: vec = '{op: OP_ADD, a: 32'hFFFF_FFFF, b: 32'h0000_0001,
                    result: 32'h0000_0000, flags: 4'b0110, mask: 4'b1111};
      3'd6: vec = '{op: OP_SUB, a: 32'h1234_5678, b: 32'h1234_5678,
                    result: 32'h0000_0000, flags: 4'b0110, mask: 4'b1111};
      3'd7: vec = '{op: OP_SUB, a: 32'h8000_0000, b: 32'h0000_0001,
                    result: 32'h7FFF_FFFF, flags: 4'b0011, mask: 4'b1111};
      default: vec = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: drives stored vectors into the ALU and checks result/flags.
// Two cycles per vector (APPLY, CHECK); start is only accepted in IDLE.
module alu_bist
  import alu_defs::*;
#(
  parameter int N            = ALU_N,
  parameter int NUM_VEC      = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   fail_count,
  output logic [2:0]   fail_index,
  output logic [N-1:0] fail_result,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         f_negative,
  input  logic         f_zero,
  input  logic         f_carry,
  input  logic         f_overFlow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_e;

  state_e       state;
  logic [2:0]   idx;
  logic [2:0]   rom_idx;
  vec_t         rom_vec;
  logic [N-1:0] exp_result;
  logic [3:0]   exp_flags;
  logic [3:0]   exp_mask;
  logic [3:0]   obs_flags;
  logic         mismatch;
  logic         last_vec;
  logic         stop_now;

  // The ROM is always addressed with the vector about to be loaded; the
  // expected fields travel with the operands so CHECK needs no second lookup.
  assign rom_idx = (state == S_IDLE) ? 3'd0 : idx + 3'd1;

  alu_bist_rom u_rom (
    .idx (rom_idx),
    .vec (rom_vec)
  );

  assign obs_flags = {f_negative, f_zero, f_carry, f_overFlow};
  assign mismatch  = (alu_result != exp_result) ||
                     (((obs_flags ^ exp_flags) & exp_mask) != 4'd0);
  assign last_vec  = (idx == 3'(NUM_VEC - 1));
  assign stop_now  = last_vec || (STOP_ON_FAIL && mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
      fail_index  <= '0;
      fail_result <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= OP_ADD;
      exp_result  <= '0;
      exp_flags   <= '0;
      exp_mask    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_APPLY;
            busy        <= 1'b1;
            idx         <= '0;
            pass        <= 1'b0;
            fail_count  <= '0;
            fail_index  <= '0;
            fail_result <= '0;
            alu_a       <= rom_vec.a;
            alu_b       <= rom_vec.b;
            alu_control <= rom_vec.op;
            exp_result  <= rom_vec.result;
            exp_flags   <= rom_vec.flags;
            exp_mask    <= rom_vec.mask;
          end
        end

        // One full cycle for the ALU to settle on the new operands.
        S_APPLY: state <= S_CHECK;

        S_CHECK: begin
          if (mismatch) begin
            if (fail_count != 4'hF) begin
              fail_count <= fail_count + 4'd1;
            end
            if (fail_count == 4'd0) begin
              fail_index  <= idx;
              fail_result <= alu_result;
            end
          end
          if (stop_now) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == 4'd0) && !mismatch;
          end else begin
            state       <= S_APPLY;
            idx         <= idx + 3'd1;
            alu_a       <= rom_vec.a;
            alu_b       <= rom_vec.b;
            alu_control <= rom_vec.op;
            exp_result  <= rom_vec.result;
            exp_flags   <= rom_vec.flags;
            exp_mask    <= rom_vec.mask;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two controllers (run-to-end and stop-on-fail) each drive
// their own behavioural ALU with selectable faults; results checked against a table model.
module tb_alu_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  busy, done, pass;
  logic [3:0]  fail_count  [2];
  logic [2:0]  fail_index  [2];
  logic [31:0] fail_result [2];
  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [2:0]  alu_ctl [2];
  logic [31:0] alu_res [2];
  logic [3:0]  alu_flg [2];

  int          fault = 0;
  logic [2:0]  fault_op = 3'b000;
  logic [31:0] fault_mask = 32'd1;

  int n_cmp = 0;
  int n_err = 0;

  // Vector table as written in the block description.
  logic [2:0]  tv_op [8] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b101, 3'b000, 3'b001, 3'b001};
  logic [31:0] tv_a  [8] = '{32'h80D00000, 32'h80D00040, 32'h7FFFFFFF, 32'h00000000,
                             32'h80D00000, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
  logic [31:0] tv_b  [8] = '{32'h80D000F0, 32'h80D000F0, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h80D000F0, 32'h00000001, 32'h12345678, 32'h00000001};
  logic [31:0] tv_r  [8] = '{32'h80D000F0, 32'h80D00040, 32'hFFFFFFFE, 32'h00000001,
                             32'h00000001, 32'h00000000, 32'h00000000, 32'h7FFFFFFF};
  logic [3:0]  tv_f  [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0011};
  logic [3:0]  tv_m  [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111};

  // Faults: 1 V stuck 0, 2 SLT returns 0, 3 Z stuck 1, 4 C inverted on SUB,
  // 5 one result bit flipped for one opcode.
  function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int flt,
                                         input logic [2:0] fop, input logic [31:0] fmask);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    if (flt == 2 && op == 3'b101) r = '0;
    if (flt == 5 && op == fop) r = r ^ fmask;
    if (flt == 4 && op == 3'b001) c = ~c;
    if (flt == 1) v = 1'b0;
    return {r, r[31], (r == 32'd0) | (flt == 3), c, v};
  endfunction

  always_comb {alu_res[0], alu_flg[0]} = alu_fn(alu_ctl[0], alu_a[0], alu_b[0], fault, fault_op, fault_mask);
  always_comb {alu_res[1], alu_flg[1]} = alu_fn(alu_ctl[1], alu_a[1], alu_b[1], fault, fault_op, fault_mask);

  alu_bist #(.N(32), .NUM_VEC(8), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_count(fail_count[0]), .fail_index(fail_index[0]), .fail_result(fail_result[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_control(alu_ctl[0]), .alu_result(alu_res[0]),
    .f_negative(alu_flg[0][3]), .f_zero(alu_flg[0][2]), .f_carry(alu_flg[0][1]), .f_overFlow(alu_flg[0][0])
  );

  alu_bist #(.N(32), .NUM_VEC(8), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_count(fail_count[1]), .fail_index(fail_index[1]), .fail_result(fail_result[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_control(alu_ctl[1]), .alu_result(alu_res[1]),
    .f_negative(alu_flg[1][3]), .f_zero(alu_flg[1][2]), .f_carry(alu_flg[1][1]), .f_overFlow(alu_flg[1][0])
  );

  // Expected outcome of one run for each controller.
  int          e_cnt  [2];
  int          e_done [2];
  logic [2:0]  e_idx;
  logic [31:0] e_res;
  logic        e_pass;

  task automatic model_expect();
    logic [35:0] o;
    int first;
    int cnt;
    first = -1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      o = alu_fn(tv_op[i], tv_a[i], tv_b[i], fault, fault_op, fault_mask);
      if (o[35:4] != tv_r[i] || ((o[3:0] ^ tv_f[i]) & tv_m[i]) != 4'd0) begin
        cnt++;
        if (first < 0) begin
          first = i;
          e_res = o[35:4];
        end
      end
    end
    e_cnt[0]  = cnt;
    e_cnt[1]  = (cnt > 0) ? 1 : 0;
    e_pass    = (cnt == 0);
    e_idx     = (first < 0) ? 3'd0 : 3'(first);
    if (first < 0) e_res = '0;
    e_done[0] = 16;
    e_done[1] = (first < 0) ? 16 : 2 * first + 2;
  endtask

  task automatic check_all_zero(input string name);
    logic [108:0] got;
    for (int d = 0; d < 2; d++) begin
      got = {busy[d], done[d], pass[d], fail_count[d], fail_index[d], fail_result[d],
             alu_a[d], alu_b[d], alu_ctl[d]};
      n_cmp++;
      if (got !== '0) begin
        n_err++;
        $display("FAIL %s outputs_zero dut%0d: got %h want 0", name, d, got);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; fault = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  // One start pulse, then observe 40 cycles; optionally poke start while busy.
  task automatic run_and_check(input string name, input int flt, input bit poke_busy);
    int done_at [2];
    int ndone [2];
    int shown;
    int lim;
    int k;
    fault = flt;
    model_expect();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;  // edge 0
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (busy[d] !== 1'b1 || pass[d] !== 1'b0 || fail_count[d] !== 4'd0) begin
        n_err++;
        $display("FAIL %s start_accept dut%0d: busy=%0b pass=%0b cnt=%0d want 1/0/0",
                 name, d, busy[d], pass[d], fail_count[d]);
      end
      done_at[d] = -1; ndone[d] = 0;
    end
    shown = 0;
    for (int c = 1; c <= 40; c++) begin
      start = poke_busy && (c >= 2) && (c <= 13) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (done[d] === 1'b1) begin
          ndone[d]++;
          if (done_at[d] < 0) done_at[d] = c;
        end
        lim = (e_done[d] - 2) / 2;
        k = (c / 2 > lim) ? lim : c / 2;
        n_cmp++;
        if (busy[d] !== (c < e_done[d]) || alu_a[d] !== tv_a[k] || alu_b[d] !== tv_b[k] ||
            alu_ctl[d] !== tv_op[k]) begin
          n_err++;
          if (shown < 4) begin
            shown++;
            $display("FAIL %s cycle%0d dut%0d: busy=%0b a=%h b=%h op=%0d want busy=%0b a=%h b=%h op=%0d",
                     name, c, d, busy[d], alu_a[d], alu_b[d], alu_ctl[d],
                     (c < e_done[d]), tv_a[k], tv_b[k], tv_op[k]);
          end
        end
      end
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (done_at[d] != e_done[d] || ndone[d] != 1) begin
        n_err++;
        $display("FAIL %s done_timing dut%0d: edge %0d x%0d want edge %0d x1",
                 name, d, done_at[d], ndone[d], e_done[d]);
      end
      n_cmp++;
      if (pass[d] !== e_pass || fail_count[d] !== 4'(e_cnt[d]) || fail_index[d] !== e_idx ||
          fail_result[d] !== e_res) begin
        n_err++;
        $display("FAIL %s result dut%0d: pass=%0b cnt=%0d idx=%0d res=%h want %0b/%0d/%0d/%h",
                 name, d, pass[d], fail_count[d], fail_index[d], fail_result[d],
                 e_pass, e_cnt[d], e_idx, e_res);
      end
    end
  endtask

  task automatic test_golden();
    run_and_check("golden", 0, 1'b0);
  endtask

  task automatic test_v_stuck();
    run_and_check("v_stuck", 1, 1'b0);
    n_cmp++;
    if (fail_count[0] !== 4'd2 || fail_index[0] !== 3'd2 || fail_result[0] !== 32'hFFFFFFFE ||
        pass[0] !== 1'b0 || fail_count[1] !== 4'd1 || fail_index[1] !== 3'd2) begin
      n_err++;
      $display("FAIL v_stuck_fixed: cnt=%0d idx=%0d res=%h pass=%0b cnt1=%0d idx1=%0d want 2/2/fffffffe/0/1/2",
               fail_count[0], fail_index[0], fail_result[0], pass[0], fail_count[1], fail_index[1]);
    end
  endtask

  task automatic test_slt_zero();
    run_and_check("slt_zero", 2, 1'b0);
    n_cmp++;
    if (fail_index[0] !== 3'd4 || fail_result[0] !== 32'd0 || fail_count[0] !== 4'd1) begin
      n_err++;
      $display("FAIL slt_zero_fixed: idx=%0d res=%h cnt=%0d want 4/00000000/1",
               fail_index[0], fail_result[0], fail_count[0]);
    end
  endtask

  task automatic test_reset_midrun();
    fault = 0;
    start = 1'b1;
    @(posedge clk); #1;  // edge 0
    start = 1'b0;
    repeat (4) @(posedge clk);  // edges 1..4
    #1 rst_n = 1'b0;
    @(posedge clk); #1;  // edge 5
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 2'b00 || busy !== 2'b00) begin
        n_err++;
        $display("FAIL midrun_reset quiet cycle%0d: done=%b busy=%b want 00/00", c, done, busy);
      end
    end
    run_and_check("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ndone;
    int first_done;
    int second_done;
    fault = 0;
    ndone = 0; first_done = -1; second_done = -1;
    start = 1'b1;
    @(posedge clk); #1;  // edge 0
    for (int c = 1; c <= 44; c++) begin
      if (c == 20) start = 1'b0;
      @(posedge clk); #1;
      if (done[0] === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 17) begin
        n_cmp++;
        if (pass[0] !== 1'b1 || busy[0] !== 1'b0) begin
          n_err++;
          $display("FAIL held_start idle_gap: pass=%0b busy=%0b want 1/0", pass[0], busy[0]);
        end
      end
      if (c == 18) begin
        n_cmp++;
        if (pass[0] !== 1'b0 || busy[0] !== 1'b1) begin
          n_err++;
          $display("FAIL held_start rerun: pass=%0b busy=%0b want 0/1", pass[0], busy[0]);
        end
      end
    end
    n_cmp++;
    if (ndone != 2 || first_done != 16 || second_done != 34 || pass[0] !== 1'b1) begin
      n_err++;
      $display("FAIL held_start done: n=%0d at %0d,%0d pass=%0b want 2 at 16,34 pass=1",
               ndone, first_done, second_done, pass[0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f;
    test_reset();
    test_golden();
    test_v_stuck();
    test_slt_zero();
    test_reset_midrun();
    run_and_check("start_while_busy", 0, 1'b1);
    test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      f = $urandom_range(0, 5);
      fault_op = tv_op[$urandom_range(0, 7)];
      fault_mask = 32'd1 << $urandom_range(0, 31);
      run_and_check($sformatf("random%0d_f%0d", r, f), f, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
